mcp_adc_responder: RTL
======================

Name: mcp_adc_responder

Overview:
- Synthesizable SPI responder that emulates an MCP3008-style ADC on the cs/sclk/din/doutb interface.
- Lets the existing SPI initiator and the temperature-threshold logic run on the board or in simulation without the physical ADC.
- Receives start and config bits, requests a sample from a parent-supplied source, and returns a null bit followed by the sample MSB-first.

Parameters:
- DATA_W, 10, sample width in bits, returned MSB-first.
- CH_BITS, 3, number of channel-select bits after SGL/DIFF.
- SYNC_STAGES, 2, synchronizer depth for cs, sclk and din.

Ports:
- clk  input  1  system clock; must run at least 8x sclk.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select from the initiator, active low.
- sclk  input  1  SPI clock from the initiator; idles low.
- din  input  1  serial data from the initiator.
- doutb  output  1  serial data to the initiator.
- doutb_oe  output  1  high while the responder drives doutb; otherwise the line is undriven.
- sample_in  input  DATA_W  sample value supplied by the parent.
- conv_req  output  1  one-clk pulse when the config is complete.
- ch_sel  output  CH_BITS  channel captured in the current frame.
- sgl_diff  output  1  SGL/DIFF bit captured in the current frame.
- busy  output  1  high from start-bit detection to frame end.
- frame_err  output  1  one-clk pulse when cs rises before the last data bit.

Behaviour:
- Reset values: doutb=0, doutb_oe=0, conv_req=0, ch_sel=0, sgl_diff=0, busy=0, frame_err=0, state=IDLE, bit counter=0.
- Synchronization and edges:
  - cs, sclk and din pass through SYNC_STAGES flops.
  - Rise and fall detect on synchronized sclk; fall and rise detect on synchronized cs. All detects are single-clk pulses.
- Data timing: din is sampled on sclk rise; doutb changes on sclk fall, matching MCP300x timing.
- States:
  - IDLE: cs high; doutb_oe=0. On cs fall -> WAIT_START.
  - WAIT_START: on each sclk rise, din=0 is ignored (leading zeros); din=1 -> CONFIG, busy=1, count=0.
  - CONFIG: sclk rises shift in SGL/DIFF, then ch_sel MSB-first; 1+CH_BITS bits total. On the rise that captures the last channel bit:
    - sgl_diff and ch_sel are updated;
    - conv_req pulses on the following clk;
    - -> SAMPLE.
  - SAMPLE:
    - sample_in is latched into the shift register exactly 1 clk after conv_req (the parent has one clk to present data).
    - On the next sclk fall: doutb_oe=1, doutb=0 (null bit), count=DATA_W -> SHIFT.
  - SHIFT: each sclk fall drives the next bit MSB-first and decrements count. After bit 0 is driven -> DONE.
  - DONE: each further sclk fall drives doutb=0. No LSB-first repeat.
- cs rise in any state:
  - next clk: state=IDLE, doutb_oe=0, doutb=0, busy=0.
  - frame_err pulses if state was CONFIG, SAMPLE, or SHIFT with bits remaining.
  - No frame_err from IDLE, WAIT_START or DONE.
- cs fall while not IDLE cannot occur without a prior rise; the rise path always handles it first.
- Simultaneous cs rise and sclk edge in the same clk: cs rise wins; the edge is discarded.
- sclk edges while cs is high are ignored.
- sample_in changes after the latch clk do not affect the frame.
- Async reset mid-frame forces reset values immediately. The initiator sees doutb undriven; no recovery other than a new cs fall.

Decomposition:
- Shared package: state enum (IDLE, WAIT_START, CONFIG, SAMPLE, SHIFT, DONE), default DATA_W/CH_BITS constants, sync-stage default.
- One natural sub-module: spi_edge_sync (per-signal synchronizer plus rise/fall pulse). Instantiated for cs and sclk; din uses the synchronizer only.

Test Plan:
- Reset, then cs high and sclk toggling -> doutb_oe=0, busy=0, no conv_req.
- cs fall; din bits 1,1,0,1,1 (start, SGL=1, ch=3'b011); sample_in=10'h2A5 -> conv_req one pulse with ch_sel=3, sgl_diff=1; after the null 0, doutb yields 1,0,1,0,1,0,0,1,0,1 on 10 successive falls.
- Two leading zeros before the start bit, ch=0, sample_in=10'h3FF -> zeros ignored; returns null, then ten 1s, then 0s on extra clocks.
- cs rises after 4 data bits are out -> frame_err pulses once, doutb_oe=0 within SYNC_STAGES+1 clks, next frame (ch=5, sample=10'h001) is correct.
- Full frame ending with cs rise after the last bit -> no frame_err. sample_in changed to 10'h000 mid-SHIFT does not alter the transmitted 10'h155.
- rst_n pulsed low mid-SHIFT -> all outputs go to reset values asynchronously; the following frame completes normally.

Source files
------------

// File: rtl/mcp_adc_responder_pkg.sv
// rtl/mcp_adc_responder_pkg.sv - shared types and defaults for the MCP3008-style ADC responder
package mcp_adc_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CONFIG,
        SAMPLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEF_DATA_W      = 10;
    localparam int DEF_CH_BITS     = 3;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop synchronizer with single-clk rise/fall pulses
import mcp_adc_responder_pkg::*;

module spi_edge_sync #(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   q;
    logic                   q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            q_d <= q;
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/mcp_adc_responder.sv
// rtl/mcp_adc_responder.sv - SPI responder emulating an MCP3008-style ADC frame
import mcp_adc_responder_pkg::*;

module mcp_adc_responder #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CH_BITS     = DEF_CH_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic               sclk,
    input  logic               din,
    output logic               doutb,
    output logic               doutb_oe,
    input  logic [DATA_W-1:0]  sample_in,
    output logic               conv_req,
    output logic [CH_BITS-1:0] ch_sel,
    output logic               sgl_diff,
    output logic               busy,
    output logic               frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [CH_BITS-1:0]     cfg_sr;
    logic [CH_BITS:0]       cfg_next;
    logic [DATA_W-1:0]      shreg;
    logic                   latch_pend;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   din_s;
    logic                   cs_rise;
    logic                   cs_fall;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // cs idles high, so its synchronizer resets high to avoid a false fall after reset
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // din has the same depth as sclk so the sampled bit lines up with the rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync <= '0;
        end else begin
            din_sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                din_sync[i] <= din_sync[i-1];
            end
        end
    end

    assign din_s    = din_sync[SYNC_STAGES-1];
    assign cfg_next = {cfg_sr, din_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            cfg_sr     <= '0;
            shreg      <= '0;
            latch_pend <= 1'b0;
            doutb      <= 1'b0;
            doutb_oe   <= 1'b0;
            conv_req   <= 1'b0;
            ch_sel     <= '0;
            sgl_diff   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            conv_req   <= 1'b0;
            frame_err  <= 1'b0;
            latch_pend <= conv_req;
            // parent gets the whole conv_req cycle to put the sample on sample_in
            if (latch_pend) begin
                shreg <= sample_in;
            end

            if (cs_rise) begin
                state     <= IDLE;
                doutb_oe  <= 1'b0;
                doutb     <= 1'b0;
                busy      <= 1'b0;
                frame_err <= (state == CONFIG) || (state == SAMPLE) ||
                             ((state == SHIFT) && (count != '0));
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (sclk_rise && din_s) begin
                            state <= CONFIG;
                            busy  <= 1'b1;
                            count <= '0;
                        end
                    end
                    CONFIG: begin
                        if (sclk_rise) begin
                            cfg_sr <= cfg_next[CH_BITS-1:0];
                            count  <= count + 1'b1;
                            if (count == CNT_W'(CH_BITS)) begin
                                sgl_diff <= cfg_next[CH_BITS];
                                ch_sel   <= cfg_next[CH_BITS-1:0];
                                conv_req <= 1'b1;
                                state    <= SAMPLE;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (sclk_fall) begin
                            doutb_oe <= 1'b1;
                            doutb    <= 1'b0;
                            count    <= CNT_W'(DATA_W);
                            state    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sclk_fall) begin
                            doutb <= shreg[DATA_W-1];
                            shreg <= {shreg[DATA_W-2:0], 1'b0};
                            count <= count - 1'b1;
                            if (count == CNT_W'(1)) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (sclk_fall) begin
                            doutb <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
